// File: rtl/multdiv_pkg.sv
// Shared encodings, FSM states and default iteration counts for the
// MULT/DIV sequencer.
package multdiv_pkg;

  localparam logic [1:0] OP_HOLD = 2'b00;
  localparam logic [1:0] OP_MULT = 2'b01;
  localparam logic [1:0] OP_DIV  = 2'b10;

  localparam int MULT_CYCLES_DEF = 32;
  localparam int DIV_CYCLES_DEF  = 33;
  localparam int CNT_W_DEF       = 6;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CLEAR   = 2'd1,
    RUN     = 2'd2,
    CAPTURE = 2'd3
  } state_e;

  function automatic logic op_legal(input logic [1:0] op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/multdiv_if.sv
// Bundle of CPU request/response and MultDiv datapath signals seen by the
// sequencer; the controller uses the slave view.
interface multdiv_if;

  logic        op_start;
  logic [1:0]  op_sel;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        rd_hilo;
  logic [31:0] md_a;
  logic [31:0] md_b;
  logic [1:0]  md_ctrl;
  logic        md_reset;
  logic [31:0] md_hi;
  logic [31:0] md_lo;
  logic        md_divzero;
  logic [31:0] hi_q;
  logic [31:0] lo_q;
  logic        busy;
  logic        stall;
  logic        done;
  logic        div_zero_exc;

  modport slave (
    input  op_start, op_sel, op_a, op_b, rd_hilo, md_hi, md_lo, md_divzero,
    output md_a, md_b, md_ctrl, md_reset, hi_q, lo_q, busy, stall, done,
           div_zero_exc
  );

  modport master (
    output op_start, op_sel, op_a, op_b, rd_hilo, md_hi, md_lo, md_divzero,
    input  md_a, md_b, md_ctrl, md_reset, hi_q, lo_q, busy, stall, done,
           div_zero_exc
  );

endinterface

// File: rtl/multdiv_iter_cnt.sv
// Iteration counter for the datapath run phase: clears, counts while enabled,
// saturates at all-ones and flags the last iteration (count == limit-1).
module multdiv_iter_cnt
  import multdiv_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  input  logic [CNT_W-1:0] limit,
  output logic             terminal
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign terminal = (cnt_q == (limit - 1'b1));

endmodule

// File: rtl/multdiv_ctrl.sv
// Sequencer between the CPU control unit and the iterative MultDiv datapath:
// latches operands, clears the datapath, runs N iterations, captures HI/LO.
module multdiv_ctrl
  import multdiv_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF,
  parameter int CNT_W       = CNT_W_DEF
) (
  input logic      clk,
  input logic      reset,
  multdiv_if.slave bus
);

  localparam logic [CNT_W-1:0] MULT_LIM = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LIM  = CNT_W'(DIV_CYCLES);

  state_e      state_q, state_d;
  logic [1:0]  op_q, op_d;
  logic [31:0] md_a_q, md_a_d;
  logic [31:0] md_b_q, md_b_d;
  logic [1:0]  md_ctrl_q, md_ctrl_d;
  logic        md_reset_q, md_reset_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        exc_q, exc_d;

  logic             cnt_term;
  logic [CNT_W-1:0] cnt_limit;

  assign cnt_limit = (op_q == OP_DIV) ? DIV_LIM : MULT_LIM;

  // Counter sits at zero outside RUN, so RUN always starts from iteration 0.
  multdiv_iter_cnt #(.CNT_W(CNT_W)) u_iter_cnt (
    .clk      (clk),
    .reset    (reset),
    .clr      (state_q != RUN),
    .en       (state_q == RUN),
    .limit    (cnt_limit),
    .terminal (cnt_term)
  );

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    md_a_d  = md_a_q;
    md_b_d  = md_b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    exc_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.op_start) begin
          if ((bus.op_sel == OP_DIV) && (bus.op_b == 32'd0)) begin
            exc_d = 1'b1;
          end else if (op_legal(bus.op_sel)) begin
            op_d    = bus.op_sel;
            md_a_d  = bus.op_a;
            md_b_d  = bus.op_b;
            state_d = CLEAR;
          end
        end
      end
      CLEAR: state_d = RUN;
      RUN: begin
        if (bus.md_divzero) begin
          exc_d   = 1'b1;
          state_d = IDLE;
        end else if (cnt_term) begin
          state_d = CAPTURE;
        end
      end
      CAPTURE: begin
        hi_d    = bus.md_hi;
        lo_d    = bus.md_lo;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Datapath controls are registered, so derive them from the next state.
    md_reset_d = (state_d == CLEAR);
    md_ctrl_d  = (state_d == RUN) ? op_d : OP_HOLD;
    busy_d     = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      op_q       <= OP_HOLD;
      md_a_q     <= '0;
      md_b_q     <= '0;
      md_ctrl_q  <= OP_HOLD;
      md_reset_q <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      exc_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      md_a_q     <= md_a_d;
      md_b_q     <= md_b_d;
      md_ctrl_q  <= md_ctrl_d;
      md_reset_q <= md_reset_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      exc_q      <= exc_d;
    end
  end

  assign bus.md_a         = md_a_q;
  assign bus.md_b         = md_b_q;
  assign bus.md_ctrl      = md_ctrl_q;
  assign bus.md_reset     = md_reset_q;
  assign bus.hi_q         = hi_q;
  assign bus.lo_q         = lo_q;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.div_zero_exc = exc_q;
  assign bus.stall        = busy_q & (bus.rd_hilo | bus.op_start);

endmodule

// File: tb/tb_multdiv_ctrl.sv
// Directed and randomized bench for multdiv_ctrl with a behavioural datapath
// stand-in and an arithmetic HI/LO reference model.
module tb_multdiv_ctrl;
  import multdiv_pkg::*;

  localparam int N_MULT = 32;
  localparam int N_DIV  = 33;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  multdiv_if bus ();

  multdiv_ctrl #(
    .MULT_CYCLES (N_MULT),
    .DIV_CYCLES  (N_DIV),
    .CNT_W       (6)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Architectural HI/LO as the CPU should see them.
  logic [31:0] ref_hi = '0;
  logic [31:0] ref_lo = '0;

  // Datapath stand-in: the result is only valid after exactly dp_need
  // iteration edges since the last clear; any other count shows a marker.
  logic [6:0]  dp_cnt;
  int          dp_need   = 0;
  logic [31:0] dp_hi_res = '0;
  logic [31:0] dp_lo_res = '0;
  logic        dp_dz     = 1'b0;

  always @(posedge clk or negedge reset) begin
    if (!reset)                                       dp_cnt <= '0;
    else if (bus.md_reset)                            dp_cnt <= '0;
    else if (bus.md_ctrl != 2'b00 && dp_cnt != 7'h7f) dp_cnt <= dp_cnt + 7'd1;
  end

  assign bus.md_hi      = (int'(dp_cnt) == dp_need) ? dp_hi_res : {16'hDEAD, 9'h0, dp_cnt};
  assign bus.md_lo      = (int'(dp_cnt) == dp_need) ? dp_lo_res : {16'hBEEF, 9'h0, dp_cnt};
  assign bus.md_divzero = dp_dz;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  // {HI, LO}: product for MULT, {remainder, quotient} for DIV.
  function automatic logic [63:0] refResult(input logic [1:0] op,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
    longint p;
    int     q;
    int     r;
    if (op == OP_MULT) begin
      p = longint'(int'(a)) * longint'(int'(b));
      return p;
    end
    q = int'(a) / int'(b);
    r = int'(a) % int'(b);
    return {r, q};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic start, input logic [1:0] sel,
                               input logic [31:0] a, input logic [31:0] b);
    bus.op_start = start;
    bus.op_sel   = sel;
    bus.op_a     = a;
    bus.op_b     = b;
  endtask

  // Issues a request in the current cycle and follows it to its done pulse.
  // Returns positioned in the done cycle so a follow-up can be issued there.
  task automatic runOp(input string tag, input logic [1:0] op,
                       input logic [31:0] a, input logic [31:0] b,
                       input int hazard_at);
    logic [63:0] r;
    int n, lat, busy_cnt, ctrl_cnt, rst_cnt;
    logic early, seen_done;
    r = refResult(op, a, b);
    n = (op == OP_DIV) ? N_DIV : N_MULT;
    dp_need   = n;
    dp_hi_res = r[63:32];
    dp_lo_res = r[31:0];

    applyStimulus(1'b1, op, a, b);
    #1;
    checkOutput({tag, "_stall_idle"}, 64'(bus.stall), 64'd0);
    step();
    applyStimulus(1'b0, 2'b00, 32'd0, 32'd0);
    checkOutput({tag, "_clear"}, 64'({bus.md_reset, bus.busy, bus.md_ctrl}), 64'b1100);
    checkOutput({tag, "_operands"}, {bus.md_a, bus.md_b}, {a, b});

    lat = 0; busy_cnt = 0; ctrl_cnt = 0; rst_cnt = 0;
    early = 1'b0; seen_done = 1'b0;
    while (!seen_done && lat < 100) begin
      if (bus.done) begin
        seen_done = 1'b1;
      end else begin
        busy_cnt += int'(bus.busy);
        ctrl_cnt += int'(bus.md_ctrl == op);
        rst_cnt  += int'(bus.md_reset);
        if (bus.hi_q !== ref_hi || bus.lo_q !== ref_lo) early = 1'b1;
        if (lat == hazard_at) begin
          applyStimulus(1'b1, OP_MULT, 32'd5, 32'd5);
          bus.rd_hilo = 1'b1;
          #1;
          checkOutput({tag, "_stall_busy"}, 64'(bus.stall), 64'd1);
        end else if (lat == hazard_at + 1) begin
          applyStimulus(1'b0, 2'b00, 32'd0, 32'd0);
          bus.rd_hilo = 1'b0;
        end
        step();
        lat++;
      end
    end

    checkOutput({tag, "_done_seen"}, 64'(seen_done), 64'd1);
    checkOutput({tag, "_latency"},   64'(lat),       64'(n + 2));
    checkOutput({tag, "_busy_cyc"},  64'(busy_cnt),  64'(n + 2));
    checkOutput({tag, "_ctrl_cyc"},  64'(ctrl_cnt),  64'(n));
    checkOutput({tag, "_rst_cyc"},   64'(rst_cnt),   64'd1);
    checkOutput({tag, "_hilo_hold"}, 64'(early),     64'd0);
    checkOutput({tag, "_hilo"},      {bus.hi_q, bus.lo_q}, r);
    checkOutput({tag, "_idle"},      64'({bus.busy, bus.div_zero_exc}), 64'd0);
    ref_hi = r[63:32];
    ref_lo = r[31:0];
  endtask

  initial begin
    logic [1:0]  op;
    logic [31:0] a, b;

    applyStimulus(1'b0, 2'b00, 32'd0, 32'd0);
    bus.rd_hilo = 1'b0;

    // Asynchronous reset, checked before any clock edge.
    #1 reset = 1'b0;
    #2;
    checkOutput("rst_flags", 64'({bus.busy, bus.done, bus.div_zero_exc, bus.md_reset, bus.stall}), 64'd0);
    checkOutput("rst_ctrl",  64'(bus.md_ctrl), 64'd0);
    checkOutput("rst_hilo",  {bus.hi_q, bus.lo_q}, 64'd0);
    checkOutput("rst_ops",   {bus.md_a, bus.md_b}, 64'd0);
    #9 reset = 1'b1;
    step();
    step();

    $display("[TB] MULT 7 x -3");
    runOp("mult_7x-3", OP_MULT, 32'd7, 32'hFFFF_FFFD, -1);
    checkOutput("mult_7x-3_const", {bus.hi_q, bus.lo_q}, 64'hFFFF_FFFF_FFFF_FFEB);
    step();
    checkOutput("mult_done_pulse", 64'({bus.done, bus.busy}), 64'd0);

    $display("[TB] DIV 100 / 7");
    runOp("div_100_7", OP_DIV, 32'd100, 32'd7, -1);
    checkOutput("div_100_7_const", {bus.hi_q, bus.lo_q}, {32'd2, 32'd14});
    step();

    $display("[TB] DIV by zero");
    applyStimulus(1'b1, OP_DIV, 32'd55, 32'd0);
    step();
    applyStimulus(1'b0, 2'b00, 32'd0, 32'd0);
    checkOutput("dz_exc",   64'({bus.div_zero_exc, bus.busy, bus.md_reset}), 64'b100);
    step();
    checkOutput("dz_pulse", 64'({bus.div_zero_exc, bus.busy, bus.done}), 64'd0);
    checkOutput("dz_hilo",  {bus.hi_q, bus.lo_q}, {ref_hi, ref_lo});

    $display("[TB] hazards during RUN and back-to-back issue");
    runOp("hazard", OP_MULT, 32'd1234, 32'hFFFF_FFB3, 10);
    runOp("done_cycle", OP_DIV, 32'hFFFF_FC18, 32'd33, -1);
    step();
    checkOutput("after_chain_idle", 64'({bus.busy, bus.done}), 64'd0);

    $display("[TB] datapath DivZero during RUN");
    dp_need = N_MULT;
    applyStimulus(1'b1, OP_MULT, 32'd9, 32'd9);
    step();
    applyStimulus(1'b0, 2'b00, 32'd0, 32'd0);
    for (int i = 0; i < 5; i++) step();
    checkOutput("rdz_running", 64'({bus.busy, bus.md_ctrl}), 64'b101);
    dp_dz = 1'b1;
    step();
    dp_dz = 1'b0;
    checkOutput("rdz_abort", 64'({bus.busy, bus.div_zero_exc, bus.done, bus.md_ctrl}), 64'b01000);
    step();
    checkOutput("rdz_quiet", 64'({bus.busy, bus.div_zero_exc, bus.done}), 64'd0);
    checkOutput("rdz_hilo",  {bus.hi_q, bus.lo_q}, {ref_hi, ref_lo});

    $display("[TB] reset in the middle of RUN");
    applyStimulus(1'b1, OP_MULT, 32'd3, 32'd4);
    step();
    applyStimulus(1'b0, 2'b00, 32'd0, 32'd0);
    for (int i = 0; i < 11; i++) step();
    #2 reset = 1'b0;
    #1;
    checkOutput("mid_rst_flags", 64'({bus.busy, bus.md_reset, bus.md_ctrl}), 64'd0);
    checkOutput("mid_rst_hilo",  {bus.hi_q, bus.lo_q}, 64'd0);
    ref_hi = '0;
    ref_lo = '0;
    #2 reset = 1'b1;
    step();
    runOp("mult_after_rst", OP_MULT, 32'hFFFF_FFFB, 32'hFFFF_FFFA, -1);
    step();

    $display("[TB] illegal op_sel values");
    applyStimulus(1'b1, 2'b11, 32'd1, 32'd2);
    step();
    applyStimulus(1'b1, 2'b00, 32'd1, 32'd2);
    checkOutput("ill11", 64'({bus.busy, bus.md_reset, bus.div_zero_exc, bus.done}), 64'd0);
    step();
    applyStimulus(1'b0, 2'b00, 32'd0, 32'd0);
    checkOutput("ill00", 64'({bus.busy, bus.md_reset, bus.div_zero_exc, bus.done}), 64'd0);
    step();
    checkOutput("ill_hilo", {bus.hi_q, bus.lo_q, 1'b0} >> 1, {ref_hi, ref_lo});

    $display("[TB] randomized back-to-back operations");
    for (int i = 0; i < 8; i++) begin
      op = ($urandom_range(0, 1) == 0) ? OP_MULT : OP_DIV;
      a  = $urandom;
      b  = (i % 2 == 1) ? 32'($urandom_range(1, 100)) : $urandom;
      if (op == OP_DIV && b == 32'd0) b = 32'd1;
      if (op == OP_DIV && b == 32'hFFFF_FFFF && a == 32'h8000_0000) b = 32'd2;
      runOp($sformatf("rnd%0d", i), op, a, b, -1);
    end
    step();
    checkOutput("rnd_end_idle", 64'({bus.busy, bus.done}), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
